memory_interface_fsm: RTL and testbench



---
 rtl/memory_interface_fsm.sv | 52 +++++
 tb/tb_memory_interface_fsm.sv | 127 ++++++++++++
 2 files changed

// File: rtl/memory_interface_fsm.sv
// Moore sequencer for single read/write accesses to an asynchronous memory.
// A master request in IDLE is qualified in DECISION, and a strobe is then held until rdy completes the access.
module memory_interface_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic       rw,
    output logic       oe,
    output logic       we,
    output logic [1:0] present_state
);

    // state    | meaning
    // IDLE     | waiting for rdy to request an access
    // DECISION | sample rw to pick the access direction
    // READ     | oe asserted until rdy completes the access
    // WRITE    | we asserted until rdy completes the access
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECISION = 2'd1,
        READ     = 2'd2,
        WRITE    = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (rdy) state_d = DECISION;
            DECISION: state_d = rw ? READ : WRITE;
            READ:     if (rdy) state_d = IDLE;
            WRITE:    if (rdy) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes come straight from the state register, so inputs never reach them combinationally.
    assign oe            = (state_q == READ);
    assign we            = (state_q == WRITE);
    assign present_state = state_q;

endmodule

// File: tb/tb_memory_interface_fsm.sv
// Directed bench for memory_interface_fsm; each step queues the expected post-edge state
// and checks state and strobes 1 ns after the rising edge.
module tb_memory_interface_fsm;

    logic       clk;
    logic       reset;
    logic       rdy;
    logic       rw;
    logic       oe;
    logic       we;
    logic [1:0] present_state;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [1:0] state;
        logic       oe;
        logic       we;
    } exp_t;

    exp_t sb[$];

    memory_interface_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .rdy           (rdy),
        .rw            (rw),
        .oe            (oe),
        .we            (we),
        .present_state (present_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs for one edge, queue the expected result, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic rd, input logic dir,
                        input logic [1:0] exp_state);
        exp_t e;
        exp_t got;
        reset = r;
        rdy   = rd;
        rw    = dir;
        e.tag   = tag;
        e.state = exp_state;
        e.oe    = (exp_state == 2'd2);
        e.we    = (exp_state == 2'd3);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({got.tag, "_state"}, 32'(present_state), 32'(got.state));
            check({got.tag, "_oe"},    32'(oe),            32'(got.oe));
            check({got.tag, "_we"},    32'(we),            32'(got.we));
            check({got.tag, "_excl"},  32'(oe & we),       32'd0);
        end
    endtask

    initial begin
        reset = 1'b0;
        rdy   = 1'b1;
        rw    = 1'b1;

        // reset held with rdy=1, rw=1: reset wins
        step("rst0", 1'b0, 1'b1, 1'b1, 2'd0);
        step("rst1", 1'b0, 1'b1, 1'b1, 2'd0);

        // write access stretched for three strobe cycles
        step("wr_req",  1'b1, 1'b1, 1'b0, 2'd1);
        step("wr_s1",   1'b1, 1'b0, 1'b0, 2'd3);
        step("wr_s2",   1'b1, 1'b0, 1'b0, 2'd3);
        step("wr_s3",   1'b1, 1'b0, 1'b0, 2'd3);
        step("wr_done", 1'b1, 1'b1, 1'b0, 2'd0);

        // continuous read, rdy held high: period of three with one-cycle oe
        for (int i = 0; i < 2; i++) begin
            step($sformatf("rd%0d_dec", i),  1'b1, 1'b1, 1'b1, 2'd1);
            step($sformatf("rd%0d_oe", i),   1'b1, 1'b1, 1'b1, 2'd2);
            step($sformatf("rd%0d_idle", i), 1'b1, 1'b1, 1'b1, 2'd0);
        end

        // rw changes during READ must not redirect the access
        step("dir_req",  1'b1, 1'b1, 1'b1, 2'd1);
        step("dir_rd",   1'b1, 1'b0, 1'b1, 2'd2);
        step("dir_tgl0", 1'b1, 1'b0, 1'b0, 2'd2);
        step("dir_tgl1", 1'b1, 1'b0, 1'b0, 2'd2);
        step("dir_done", 1'b1, 1'b1, 1'b0, 2'd0);

        // idle hold with rdy low
        step("idle_rst", 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 2'd0);
        end

        // reset abandons a write in progress
        step("mid_req", 1'b1, 1'b1, 1'b0, 2'd1);
        step("mid_wr",  1'b1, 1'b0, 1'b0, 2'd3);
        step("mid_rst", 1'b0, 1'b0, 1'b0, 2'd0);

        // reset abandons a read in progress; DECISION ignores rdy=0
        step("mrd_req", 1'b1, 1'b1, 1'b1, 2'd1);
        step("mrd_rd",  1'b1, 1'b0, 1'b1, 2'd2);
        step("mrd_rst", 1'b0, 1'b1, 1'b1, 2'd0);
        step("mrd_idl", 1'b1, 1'b0, 1'b1, 2'd0);

        if (sb.size() != 0) begin
            check("sb_leftover", 32'(sb.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
